// File: rtl/dport_scramble_if.sv
// dport_scramble_if: symbol, K-flag and mode bundle between the framing stage and the scrambler.
interface dport_scramble_if;
    logic [15:0] dpdat0;
    logic [15:0] dpdat1;
    logic [1:0]  dpisk0;
    logic [1:0]  dpisk1;
    logic        scramble_en;
    logic        train;
    logic [15:0] scrdat0;
    logic [15:0] scrdat1;
    logic [1:0]  scrisk0;
    logic [1:0]  scrisk1;
    modport master (
        output dpdat0, dpdat1, dpisk0, dpisk1, scramble_en, train,
        input  scrdat0, scrdat1, scrisk0, scrisk1
    );
    modport slave (
        input  dpdat0, dpdat1, dpisk0, dpisk1, scramble_en, train,
        output scrdat0, scrdat1, scrisk0, scrisk1
    );
endinterface

// File: rtl/dport_scramble.sv
// dport_scramble: two-lane DisplayPort data scrambler, 2 symbols/lane/clock, every SRPERIOD-th BS becomes SR.
module dport_scramble #(
    parameter logic [15:0] SEED     = 16'hFFFF,
    parameter int          SRPERIOD = 512
) (
    input logic             dpclk,
    input logic             reset,
    dport_scramble_if.slave bus
);
    localparam logic [7:0] SYM_BS = 8'hBC;
    localparam logic [7:0] SYM_SR = 8'h1C;
    localparam int CW = (SRPERIOD > 1) ? $clog2(SRPERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SRPERIOD - 1);

    logic [15:0]   r_lfsr;
    logic [15:0]   w_lfsr;
    logic [CW-1:0] r_bscnt;
    logic [CW-1:0] w_bscnt;
    logic [15:0]   r_dat0;
    logic [15:0]   r_dat1;
    logic [1:0]    r_isk0;
    logic [1:0]    r_isk1;
    logic [15:0]   w_dat0;
    logic [15:0]   w_dat1;
    logic [7:0]    w_ks;
    logic [7:0]    w_b0;
    logic [7:0]    w_b1;
    logic          w_bs0;
    logic          w_rep;

    // Lane 0 owns the BS/SR decision at each position; lane 1 only follows it when it also carries BS.
    always_comb begin
        w_lfsr  = r_lfsr;
        w_bscnt = r_bscnt;
        w_dat0  = bus.dpdat0;
        w_dat1  = bus.dpdat1;
        w_ks    = '0;
        w_b0    = '0;
        w_b1    = '0;
        w_bs0   = 1'b0;
        w_rep   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                w_ks[i] = w_lfsr[15];
                w_lfsr  = {w_lfsr[14:0], 1'b0} ^ (w_lfsr[15] ? 16'h0039 : 16'h0000);
            end
            w_b0  = bus.dpdat0[8*p +: 8];
            w_b1  = bus.dpdat1[8*p +: 8];
            w_bs0 = bus.dpisk0[p] && (w_b0 == SYM_BS);
            w_rep = w_bs0 && (w_bscnt == LAST);
            if (w_bs0)
                w_bscnt = w_rep ? '0 : w_bscnt + 1'b1;
            if (w_rep || (bus.dpisk0[p] && (w_b0 == SYM_SR)))
                w_lfsr = SEED;
            w_dat0[8*p +: 8] = w_rep ? SYM_SR :
                               (bus.dpisk0[p] || !bus.scramble_en) ? w_b0 : w_b0 ^ w_ks;
            w_dat1[8*p +: 8] = (w_rep && bus.dpisk1[p] && (w_b1 == SYM_BS)) ? SYM_SR :
                               (bus.dpisk1[p] || !bus.scramble_en) ? w_b1 : w_b1 ^ w_ks;
        end
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            r_dat0  <= '0;
            r_dat1  <= '0;
            r_isk0  <= '0;
            r_isk1  <= '0;
            r_lfsr  <= SEED;
            r_bscnt <= '0;
        end else if (bus.train) begin
            r_dat0  <= bus.dpdat0;
            r_dat1  <= bus.dpdat1;
            r_isk0  <= bus.dpisk0;
            r_isk1  <= bus.dpisk1;
            r_lfsr  <= SEED;
            r_bscnt <= '0;
        end else begin
            r_dat0  <= w_dat0;
            r_dat1  <= w_dat1;
            r_isk0  <= bus.dpisk0;
            r_isk1  <= bus.dpisk1;
            r_lfsr  <= w_lfsr;
            r_bscnt <= w_bscnt;
        end
    end

    assign bus.scrdat0 = r_dat0;
    assign bus.scrdat1 = r_dat1;
    assign bus.scrisk0 = r_isk0;
    assign bus.scrisk1 = r_isk1;
endmodule
